// File: rtl/decoder_strobe_sequencer.sv
// Upstream driver for a 2-to-4 write-select decoder: 2-entry request FIFO plus a
// setup/strobe/hold sequencer. Define DECSEQ_SWEEP_EN to add the four-address sweep request.
module decoder_strobe_sequencer #(
   parameter int SETUP_CYCLES  = 2,
   parameter int STROBE_CYCLES = 1,
   parameter int HOLD_CYCLES   = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_addr,
`ifdef DECSEQ_SWEEP_EN
   input  logic       req_sweep,
`endif
   output logic       address0,
   output logic       address1,
   output logic       enable,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
   localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
   localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES - 1);

   state_t     state, state_next;
   logic [7:0] counter, counter_next;
   logic [1:0] addr_q, addr_next;
   logic [1:0] fifo_addr [2];
   logic [1:0] fifo_count;
   logic       wr_ptr, rd_ptr;
   logic       push, pop;
   logic       head_sweep, sweep_active, sweep_more;

   assign req_ready = (fifo_count != 2'd2);
   assign push      = req_valid && req_ready;
   assign busy      = (fifo_count != 2'd0) || (state != IDLE);
   assign address0  = addr_q[0];
   assign address1  = addr_q[1];

`ifdef DECSEQ_SWEEP_EN
   logic fifo_sweep [2];
   logic sweep_next;
   assign head_sweep = fifo_sweep[rd_ptr];
   assign sweep_more = sweep_active && (addr_q != 2'd3);
`else
   assign head_sweep   = 1'b0;
   assign sweep_active = 1'b0;
   assign sweep_more   = 1'b0;
`endif

   // NOTE: storage has no reset; the count and pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= req_addr;
`ifdef DECSEQ_SWEEP_EN
         fifo_sweep[wr_ptr] <= req_sweep;
`endif
      end
   end

   // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         fifo_count <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // State register; enable is its own flop so the decoder never sees a state-decode glitch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         counter <= 8'd0;
         addr_q  <= 2'd0;
         enable  <= 1'b0;
      end else begin
         state   <= state_next;
         counter <= counter_next;
         addr_q  <= addr_next;
         enable  <= (state_next == STROBE);
      end
   end

`ifdef DECSEQ_SWEEP_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sweep_active <= 1'b0;
      else          sweep_active <= sweep_next;
   end
`endif

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (fifo_count != 2'd0) state_next = SETUP;
         SETUP:   if (counter == 8'd0)    state_next = STROBE;
         STROBE:  if (counter == 8'd0)    state_next = HOLD;
         HOLD:    if (counter == 8'd0)    state_next = sweep_more ? SETUP : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      pop          = 1'b0;
      counter_next = counter;
      addr_next    = addr_q;
`ifdef DECSEQ_SWEEP_EN
      sweep_next   = sweep_active;
`endif
      case (state)
         IDLE: begin
            if (fifo_count != 2'd0) begin
               pop          = 1'b1;
               addr_next    = head_sweep ? 2'd0 : fifo_addr[rd_ptr];
               counter_next = SETUP_LOAD;
`ifdef DECSEQ_SWEEP_EN
               sweep_next   = head_sweep;
`endif
            end
         end
         SETUP:  counter_next = (counter == 8'd0) ? STROBE_LOAD : counter - 8'd1;
         STROBE: counter_next = (counter == 8'd0) ? HOLD_LOAD : counter - 8'd1;
         HOLD: begin
            if (counter != 8'd0) begin
               counter_next = counter - 8'd1;
            end else if (sweep_more) begin
               addr_next    = addr_q + 2'd1;
               counter_next = SETUP_LOAD;
            end else begin
`ifdef DECSEQ_SWEEP_EN
               sweep_next   = 1'b0;
`endif
            end
         end
         default: counter_next = 8'd0;
      endcase
   end

endmodule

// File: tb/tb_decoder_strobe_sequencer.sv
// Self-checking bench: vector table, hand-written corner sequences and a randomized run
// against a request-schedule model of the sequencer.
module tb_decoder_strobe_sequencer;

   localparam int S = 2, T = 1, H = 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid, ready, a0, a1, en, busy, sweep;
   logic [1:0] addr;
   logic       c_valid, c_ready, c_a0, c_a1, c_en, c_busy, c_sweep;
   logic [1:0] c_addr;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   decoder_strobe_sequencer #(.SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H)) dut (
      .clk(clk), .reset_n(rst_n), .req_valid(valid), .req_ready(ready), .req_addr(addr),
`ifdef DECSEQ_SWEEP_EN
      .req_sweep(sweep),
`endif
      .address0(a0), .address1(a1), .enable(en), .busy(busy));

   decoder_strobe_sequencer #(.SETUP_CYCLES(1), .STROBE_CYCLES(3), .HOLD_CYCLES(1)) dut_c (
      .clk(clk), .reset_n(rst_n), .req_valid(c_valid), .req_ready(c_ready), .req_addr(c_addr),
`ifdef DECSEQ_SWEEP_EN
      .req_sweep(c_sweep),
`endif
      .address0(c_a0), .address1(c_a1), .enable(c_en), .busy(c_busy));

   // Output bundle order: {ready, enable, address1, address0, busy}
   function automatic logic [4:0] pk(logic r, logic e, logic [1:0] ad, logic b);
      return {r, e, ad[1], ad[0], b};
   endfunction

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      valid = 1'b0; sweep = 1'b0; c_valid = 1'b0; c_sweep = 1'b0;
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   // Schedule model: request i accepted at edge a_i is popped at
   // p_i = max(a_i+1, p_{i-1}+S+T+H+1); every output follows from those edge numbers.
   int         m_a[$], m_p[$];
   logic [1:0] m_ad[$];
   int         m_k, m_plast;

   function automatic logic [4:0] model_exp(int k);
      int         cnt = 0;
      logic       e = 1'b0, b = 1'b0;
      logic [1:0] ad = 2'd0;
      foreach (m_a[i]) begin
         if (m_a[i] <= k) cnt++;
         if (m_p[i] <= k) begin
            cnt--;
            ad = m_ad[i];
            if (k <= m_p[i] + S + T + H - 1) b = 1'b1;
            if (k >= m_p[i] + S && k <= m_p[i] + S + T - 1) e = 1'b1;
         end
      end
      if (cnt != 0) b = 1'b1;
      return pk(cnt != 2, e, ad, b);
   endfunction

   task automatic model_start();
      m_a.delete(); m_p.delete(); m_ad.delete();
      m_k = -1; m_plast = -1000;
   endtask

   task automatic model_cycle(input string name, input logic v, input logic [1:0] ad,
                              output logic acc);
      logic [4:0] exp;
      int         p;
      @(negedge clk);
      exp = model_exp(m_k);
      check(name, pk(ready, en, {a1, a0}, busy), exp);
      valid = v; addr = ad; sweep = 1'b0;
      acc = v && exp[4];
      if (acc) begin
         p = (m_k + 2 > m_plast + S + T + H + 1) ? m_k + 2 : m_plast + S + T + H + 1;
         m_a.push_back(m_k + 1); m_p.push_back(p); m_ad.push_back(ad);
         m_plast = p;
      end
      m_k++;
   endtask

   typedef struct {
      logic       valid;
      logic [1:0] addr;
      logic [4:0] exp;
   } vec_t;

   initial begin
      vec_t       tbl[8];
      logic       acc, prev_en;
      logic [1:0] seq[3];
      int         idx, waited;
      int         rise_k[$];
      logic [1:0] rise_ad[$];

      // Reset with no clock edge yet
      rst_n = 1'b0; valid = 1'b0; addr = 2'd0; sweep = 1'b0;
      c_valid = 1'b0; c_addr = 2'd0; c_sweep = 1'b0;
      #1 check("reset_initial", pk(ready, en, {a1, a0}, busy), 5'b10000);
      #1 rst_n = 1'b1;

      // Single request addr 2, defaults; entry i checks the state after edge i-1
      tbl[0] = '{1'b1, 2'd2, 5'b10000};
      tbl[1] = '{1'b0, 2'd0, 5'b10001};
      tbl[2] = '{1'b0, 2'd0, 5'b10101};
      tbl[3] = '{1'b0, 2'd0, 5'b10101};
      tbl[4] = '{1'b0, 2'd0, 5'b11101};
      tbl[5] = '{1'b0, 2'd0, 5'b10101};
      tbl[6] = '{1'b0, 2'd0, 5'b10100};
      tbl[7] = '{1'b0, 2'd0, 5'b10100};
      foreach (tbl[i]) begin
         @(negedge clk);
         check($sformatf("single_vec%0d", i), pk(ready, en, {a1, a0}, busy), tbl[i].exp);
         valid = tbl[i].valid; addr = tbl[i].addr;
      end

      // Back-pressure: valid held high with 1, 3, 0
      do_reset();
      model_start();
      seq[0] = 2'd1; seq[1] = 2'd3; seq[2] = 2'd0;
      idx = 0; prev_en = 1'b0;
      for (int c = 0; c < 22; c++) begin
         if (idx < 3) model_cycle("backpressure", 1'b1, seq[idx], acc);
         else         model_cycle("backpressure", 1'b0, 2'd0, acc);
         if (acc) idx++;
         if (en && !prev_en) begin rise_k.push_back(c); rise_ad.push_back({a1, a0}); end
         if (en && prev_en) check("addr_stable_during_enable", 5'({a1, a0}), 5'(rise_ad[$]));
         prev_en = en;
      end
      check("pulse_count", 5'(rise_k.size()), 5'd3);
      if (rise_k.size() == 3) begin
         for (int i = 0; i < 3; i++) check($sformatf("pulse%0d_addr", i), 5'(rise_ad[i]), 5'(seq[i]));
         check("pulse_spacing01", 5'(rise_k[1] - rise_k[0]), 5'd5);
         check("pulse_spacing12", 5'(rise_k[2] - rise_k[1]), 5'd5);
      end

      // Parameter corner S=1, T=3, H=1 with addr 3 at edge 0
      do_reset();
      @(negedge clk);
      c_valid = 1'b1; c_addr = 2'd3;
      for (int k = 0; k <= 7; k++) begin
         @(negedge clk);
         c_valid = 1'b0;
         check($sformatf("corner_k%0d", k), pk(c_ready, c_en, {c_a1, c_a0}, c_busy),
               pk(1'b1, k >= 2 && k <= 4, (k >= 1) ? 2'd3 : 2'd0, k <= 5));
      end

      // Reset mid-strobe with one entry queued
      do_reset();
      @(negedge clk); valid = 1'b1; addr = 2'd1;
      @(negedge clk); valid = 1'b1; addr = 2'd2;
      @(negedge clk); valid = 1'b0;
      waited = 0;
      while (!en && waited < 20) begin @(negedge clk); waited++; end
      check("strobe_reached", 5'(en), 5'd1);
      check("entry_queued", 5'(busy), 5'd1);
      #2 rst_n = 1'b0;
      #1 check("reset_mid_strobe", pk(ready, en, {a1, a0}, busy), 5'b10000);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         check("after_reset_idle", pk(ready, en, {a1, a0}, busy), 5'b10000);
      end

      // Randomized traffic against the schedule model
      do_reset();
      model_start();
      for (int c = 0; c < 400; c++)
         model_cycle("random", ($urandom % 3) != 0, 2'($urandom), acc);
      for (int c = 0; c < 40; c++) model_cycle("random_drain", 1'b0, 2'd0, acc);

`ifdef DECSEQ_SWEEP_EN
      // One sweep request: pulses at edges 3,7,11,15 with addresses 0..3
      do_reset();
      @(negedge clk);
      valid = 1'b1; sweep = 1'b1; addr = 2'd2;
      for (int k = 0; k <= 18; k++) begin
         @(negedge clk);
         valid = 1'b0; sweep = 1'b0;
         check($sformatf("sweep_k%0d", k), pk(ready, en, {a1, a0}, busy),
               pk(1'b1, k >= 3 && k <= 15 && ((k - 3) % 4) == 0,
                  (k < 1) ? 2'd0 : (k >= 13) ? 2'd3 : 2'((k - 1) / 4), k <= 16));
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
